// File: rtl/data_memory_sync.sv
// Clocked, word-organised data memory with byte-lane writes, programmable wait states
// and a read-only counter word overlaid at CONT_ADDR; Ready/Busy/Error handshake.
module data_memory_sync #(
  parameter int unsigned                DATAWIDTH_BUS = 32,
  parameter int unsigned                DEPTH         = 1024,
  parameter int unsigned                WAIT_STATES   = 0,
  parameter logic [DATAWIDTH_BUS-1:0]   CONT_ADDR     = 32'h8,
  parameter                             INIT_FILE     = ""
) (
  input  logic                          DataMemory_CLOCK_50,
  input  logic                          DataMemory_RESET_InLow,
  input  logic [DATAWIDTH_BUS-1:0]      DataMemory_Address_In,
  input  logic [DATAWIDTH_BUS-1:0]      DataMemory_Data_In,
  input  logic [DATAWIDTH_BUS/8-1:0]    DataMemory_ByteEn_In,
  input  logic                          DataMemory_Selector_RD,
  input  logic                          DataMemory_Selector_WR,
  input  logic [DATAWIDTH_BUS-1:0]      DataMemory_Cont,
  output logic [DATAWIDTH_BUS-1:0]      DataMemory_Data_Out,
  output logic                          DataMemory_Ready_Out,
  output logic                          DataMemory_Busy_Out,
  output logic                          DataMemory_Error_Out
);

  localparam int unsigned NB = DATAWIDTH_BUS / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATAWIDTH_BUS-1:0] ALIGN_MASK = DATAWIDTH_BUS'(NB - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [DATAWIDTH_BUS-1:0]   addr_q;
  logic [DATAWIDTH_BUS-1:0]   wdata_q;
  logic [NB-1:0]              be_q;
  logic                       rd_q;
  logic                       wr_q;
  logic                       err_q;
  logic [3:0]                 cnt_q;
  logic [DATAWIDTH_BUS-1:0]   dout_q;

  logic [DATAWIDTH_BUS-1:0]   mem [DEPTH];

  logic                       req;
  logic                       accept;
  logic                       is_cont_in;
  logic                       err_in;
  logic [DATAWIDTH_BUS-1:0]   word_idx_in;
  logic [AW-1:0]              ram_idx;
  logic                       done;
  logic                       rd_ok;
  logic                       wr_ok;
  logic [DATAWIDTH_BUS-1:0]   rd_data;

  // Request classification happens at acceptance so the access itself is a single DONE cycle.
  always_comb begin
    req         = DataMemory_Selector_RD | DataMemory_Selector_WR;
    accept      = (state_q == S_IDLE) && req;
    word_idx_in = DataMemory_Address_In >> LB;
    is_cont_in  = (DataMemory_Address_In == CONT_ADDR);
    err_in      = (DataMemory_Selector_RD & DataMemory_Selector_WR)
                | (|(DataMemory_Address_In & ALIGN_MASK))
                | ((word_idx_in >= DATAWIDTH_BUS'(DEPTH)) & ~is_cont_in)
                | (DataMemory_Selector_WR & is_cont_in);
  end

  always_comb begin
    done    = (state_q == S_DONE);
    rd_ok   = done & rd_q & ~err_q;
    wr_ok   = done & wr_q & ~err_q;
    ram_idx = AW'(addr_q >> LB);
    rd_data = (addr_q == CONT_ADDR) ? DataMemory_Cont : mem[ram_idx];
  end

  always_ff @(posedge DataMemory_CLOCK_50 or negedge DataMemory_RESET_InLow) begin
    if (!DataMemory_RESET_InLow) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = (WAIT_STATES > 0) ? S_WAIT : S_DONE;
      S_WAIT:  if (cnt_q <= 4'd1) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    DataMemory_Ready_Out = done;
    DataMemory_Busy_Out  = (state_q != S_IDLE);
    DataMemory_Error_Out = done & err_q;
    DataMemory_Data_Out  = rd_ok ? rd_data : dout_q;
  end

  always_ff @(posedge DataMemory_CLOCK_50 or negedge DataMemory_RESET_InLow) begin
    if (!DataMemory_RESET_InLow) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= DataMemory_Address_In;
        wdata_q <= DataMemory_Data_In;
        be_q    <= DataMemory_ByteEn_In;
        rd_q    <= DataMemory_Selector_RD & ~DataMemory_Selector_WR;
        wr_q    <= DataMemory_Selector_WR & ~DataMemory_Selector_RD;
        err_q   <= err_in;
        cnt_q   <= 4'(WAIT_STATES);
      end else if (state_q == S_WAIT) begin
        cnt_q   <= cnt_q - 4'd1;
      end
      if (rd_ok) begin
        dout_q <= rd_data;
      end
    end
  end

  // RAM is deliberately outside the reset domain; reset only prevents a pending commit.
  always_ff @(posedge DataMemory_CLOCK_50) begin
    if (wr_ok) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be_q[i]) begin
          mem[ram_idx][i*8 +: 8] <= wdata_q[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_sync.sv
// Directed bench: vector table on a zero-wait instance, hand sequences on a 3-wait-state instance.
module tb_data_memory_sync;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Zero-wait-state instance
    logic        rst0_n;
    logic [31:0] addr0, din0, cont0, dout0;
    logic [3:0]  be0;
    logic        rd0, wr0, rdy0, busy0, err0;

    // Three-wait-state instance
    logic        rst1_n;
    logic [31:0] addr1, din1, cont1, dout1;
    logic [3:0]  be1;
    logic        rd1, wr1, rdy1, busy1, err1;

    data_memory_sync #(.DATAWIDTH_BUS(32), .DEPTH(1024), .WAIT_STATES(0), .CONT_ADDR(32'h8)) dut0 (
        .DataMemory_CLOCK_50    (clk),
        .DataMemory_RESET_InLow (rst0_n),
        .DataMemory_Address_In  (addr0),
        .DataMemory_Data_In     (din0),
        .DataMemory_ByteEn_In   (be0),
        .DataMemory_Selector_RD (rd0),
        .DataMemory_Selector_WR (wr0),
        .DataMemory_Cont        (cont0),
        .DataMemory_Data_Out    (dout0),
        .DataMemory_Ready_Out   (rdy0),
        .DataMemory_Busy_Out    (busy0),
        .DataMemory_Error_Out   (err0)
    );

    data_memory_sync #(.DATAWIDTH_BUS(32), .DEPTH(1024), .WAIT_STATES(3), .CONT_ADDR(32'h8)) dut1 (
        .DataMemory_CLOCK_50    (clk),
        .DataMemory_RESET_InLow (rst1_n),
        .DataMemory_Address_In  (addr1),
        .DataMemory_Data_In     (din1),
        .DataMemory_ByteEn_In   (be1),
        .DataMemory_Selector_RD (rd1),
        .DataMemory_Selector_WR (wr1),
        .DataMemory_Cont        (cont1),
        .DataMemory_Data_Out    (dout1),
        .DataMemory_Ready_Out   (rdy1),
        .DataMemory_Busy_Out    (busy1),
        .DataMemory_Error_Out   (err1)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] cont;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic req0(input vec_t v, input int idx);
        @(negedge clk);
        rd0 = v.rd; wr0 = v.wr; addr0 = v.addr; din0 = v.data; be0 = v.be; cont0 = v.cont;
        @(negedge clk);
        chk($sformatf("vec%0d ready", idx), {31'd0, rdy0}, 32'd1);
        chk($sformatf("vec%0d error", idx), {31'd0, err0}, {31'd0, v.exp_err});
        chk($sformatf("vec%0d data", idx), dout0, v.exp_data);
        rd0 = 1'b0; wr0 = 1'b0;
        @(negedge clk);
        chk($sformatf("vec%0d ready_drop", idx), {31'd0, rdy0}, 32'd0);
    endtask

    task automatic req1(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic [31:0] exp_data, input logic exp_err,
                        input string name, input logic mid_pulse);
        int lat = 0;
        int busyc = 0;
        int rdyc = 0;
        @(negedge clk);
        rd1 = rd; wr1 = wr; addr1 = addr; din1 = data; be1 = be;
        @(negedge clk);
        rd1 = 1'b0; wr1 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (busy1) busyc++;
            if (rdy1) begin
                rdyc++;
                if (lat == 0) begin
                    lat = c;
                    chk({name, " data"}, dout1, exp_data);
                    chk({name, " error"}, {31'd0, err1}, {31'd0, exp_err});
                end
            end
            if (mid_pulse && c == 2) begin rd1 = 1'b1; addr1 = 32'h6; end
            if (mid_pulse && c == 3) rd1 = 1'b0;
            if (c < 12) @(negedge clk);
        end
        chk({name, " latency"}, 32'(lat), 32'd4);
        chk({name, " busy_cycles"}, 32'(busyc), 32'd4);
        chk({name, " ready_count"}, 32'(rdyc), 32'd1);
    endtask

    initial begin
        // rd, wr, addr, data, be, cont, exp_data, exp_err
        vecs[0]  = '{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,  32'h0,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 32'h0,  32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h10,   32'h000000AA, 4'h1, 32'h0,  32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 32'h0,  32'hDEADBEAA, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h8,    32'h0,        4'h0, 32'h2A, 32'h0000002A, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h8,    32'h12345678, 4'hF, 32'h2A, 32'h0000002A, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'h8,    32'h0,        4'h0, 32'h2B, 32'h0000002B, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h6,    32'h0,        4'h0, 32'h2B, 32'h0000002B, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h1000, 32'h0,        4'h0, 32'h2B, 32'h0000002B, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 32'h10,   32'h0,        4'hF, 32'h2B, 32'h0000002B, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 32'h2B, 32'hDEADBEAA, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h1000, 32'h55,       4'hF, 32'h0,  32'hDEADBEAA, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'hFFC,  32'hCAFEF00D, 4'hF, 32'h0,  32'hDEADBEAA, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 32'hFFC,  32'h0,        4'h0, 32'h0,  32'hCAFEF00D, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 32'h10,   32'hFFFFFFFF, 4'h0, 32'h0,  32'hCAFEF00D, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 32'h0,  32'hDEADBEAA, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 32'h10,   32'hA5A5A5A5, 4'hA, 32'h0,  32'hDEADBEAA, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 32'h0,  32'hA5ADA5AA, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 32'h1002, 32'h0,        4'h0, 32'h0,  32'hA5ADA5AA, 1'b1};

        rst0_n = 1'b0; rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; din0 = '0; be0 = '0; cont0 = '0;
        rst1_n = 1'b0; rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0; be1 = '0; cont1 = '0;
        repeat (3) @(negedge clk);
        chk("rst0 data", dout0, 32'h0);
        chk("rst0 ready", {31'd0, rdy0}, 32'd0);
        chk("rst0 busy", {31'd0, busy0}, 32'd0);
        chk("rst0 error", {31'd0, err0}, 32'd0);
        rst0_n = 1'b1; rst1_n = 1'b1;
        @(negedge clk);
        chk("post_rst0 ready", {31'd0, rdy0}, 32'd0);
        chk("post_rst1 busy", {31'd0, busy1}, 32'd0);
        chk("post_rst1 data", dout1, 32'h0);

        for (int i = 0; i < NV; i++) req0(vecs[i], i);

        // Wait-state timing with an ignored mid-busy read pulse
        req1(1'b0, 1'b1, 32'h800, 32'h0BADF00D, 4'hF, 32'h0,        1'b0, "ws_wr800", 1'b0);
        req1(1'b1, 1'b0, 32'h800, 32'h0,        4'h0, 32'h0BADF00D, 1'b0, "ws_rd800", 1'b1);

        // Reset during WAIT of a pending write must not commit it
        req1(1'b0, 1'b1, 32'h20, 32'h11111111, 4'hF, 32'h0BADF00D, 1'b0, "ws_wr20", 1'b0);
        @(negedge clk);
        wr1 = 1'b1; addr1 = 32'h20; din1 = 32'h22222222; be1 = 4'hF;
        @(negedge clk);
        wr1 = 1'b0;
        chk("abort busy_before", {31'd0, busy1}, 32'd1);
        #2 rst1_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("abort ready_in_reset%0d", c), {31'd0, rdy1}, 32'd0);
            chk($sformatf("abort busy_in_reset%0d", c), {31'd0, busy1}, 32'd0);
        end
        rst1_n = 1'b1;
        @(negedge clk);
        chk("abort ready_after", {31'd0, rdy1}, 32'd0);
        req1(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11111111, 1'b0, "abort_rd20", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
